sram_1r1w_param_ctrl: RTL and testbench

// Parametrised single-clock 1R1W SRAM model for the next generation of SRAM

---
 rtl/sram_1r1w_param_ctrl.sv | 149 ++++++++++++++
 tb/tb_sram_1r1w_param_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sram_1r1w_param_ctrl.sv
// Parametrised single-clock 1R1W SRAM model with byte-lane write mask,
// selectable read latency and collision policy, and a post-reset clearing sweep.
module sram_1r1w_param_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 6,
  parameter int READ_LAT     = 1,
  parameter bit BYPASS       = 1'b1,
  parameter bit CLEAR_ON_RST = 1'b1,
  localparam int NUM_WMASKS  = DATA_WIDTH / 8
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  csb0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_vld,
  output logic                  ready
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  generate
    if ((DATA_WIDTH % 8) != 0 || (READ_LAT != 1 && READ_LAT != 2)) begin : g_bad_param
      $error("sram_1r1w_param_ctrl: DATA_WIDTH must be a multiple of 8 and READ_LAT 1 or 2");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem_r [RAM_DEPTH];
  logic [0:0]            state_r;
  logic                  ready_r;
  logic [ADDR_WIDTH-1:0] clr_cnt_r;
  logic [DATA_WIDTH-1:0] dout_p1_r;
  logic                  vld_p1_r;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic                  collide_s;
  logic [DATA_WIDTH-1:0] wr_word_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NUM_WMASKS-1:0] mask
  );
    logic [DATA_WIDTH-1:0] w;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      w[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return w;
  endfunction

  // Ports are dead during reset and while the clear sweep runs.
  assign wr_en_s   = ready_r & ~csb0 & ~rst0;
  assign rd_en_s   = ready_r & ~csb1 & ~rst0;
  assign collide_s = wr_en_s & (addr0 == addr1);
  assign wr_word_s = lane_merge(mem_r[addr0], din0, wmask0);

  // Read data source: bypass the merged write word on a same-address collision.
  always_comb begin
    rd_word_s = mem_r[addr1];
    if (BYPASS && collide_s) begin
      rd_word_s = wr_word_s;
    end else begin
      rd_word_s = mem_r[addr1];
    end
  end

  // Control FSM: clear sweep after reset, then live ports until the next reset.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_r   <= CLEAR_ON_RST ? ST_CLEAR : ST_READY;
      ready_r   <= 1'b0;
      clr_cnt_r <= {ADDR_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_CLEAR: begin
          clr_cnt_r <= clr_cnt_r + ADDR_WIDTH'(1);
          if (clr_cnt_r == LAST_ADDR) begin
            state_r <= ST_READY;
            ready_r <= 1'b1;
          end
        end
        ST_READY: ready_r <= 1'b1;
        default: begin
          state_r <= ST_CLEAR;
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Storage array: one word zeroed per cycle during the sweep, else masked writes.
  always_ff @(posedge clk0) begin
    if (!rst0 && state_r == ST_CLEAR) begin
      mem_r[clr_cnt_r] <= {DATA_WIDTH{1'b0}};
    end else if (wr_en_s) begin
      mem_r[addr0] <= wr_word_s;
    end
  end

  // First read stage: data holds between reads, strobe only on an accepted read.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      dout_p1_r <= {DATA_WIDTH{1'b0}};
      vld_p1_r  <= 1'b0;
    end else begin
      vld_p1_r <= rd_en_s;
      if (rd_en_s) begin
        dout_p1_r <= rd_word_s;
      end
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] dout_p2_r;
      logic                  vld_p2_r;

      // Optional output pipeline stage.
      always_ff @(posedge clk0) begin
        if (rst0) begin
          dout_p2_r <= {DATA_WIDTH{1'b0}};
          vld_p2_r  <= 1'b0;
        end else begin
          vld_p2_r <= vld_p1_r;
          if (vld_p1_r) begin
            dout_p2_r <= dout_p1_r;
          end
        end
      end

      assign dout1     = dout_p2_r;
      assign dout1_vld = vld_p2_r;
    end else begin : g_lat1
      assign dout1     = dout_p1_r;
      assign dout1_vld = vld_p1_r;
    end
  endgenerate

  assign ready = ready_r;

endmodule

// File: tb/tb_sram_1r1w_param_ctrl.sv
// Randomised scoreboard bench: two instances (latency 1 with bypass, latency 2
// without) share stimulus and are compared against a word-array reference.
module tb_sram_1r1w_param_ctrl;
  localparam int DEPTH = 64;

  typedef struct packed {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic        clk0 = 1'b0;
  logic        rst0, csb0, csb1;
  logic [3:0]  wmask0;
  logic [5:0]  addr0, addr1;
  logic [31:0] din0;
  logic [31:0] dout_a, dout_b;
  logic        vld_a, vld_b, rdy_a, rdy_b;

  always #5 clk0 = ~clk0;

  sram_1r1w_param_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .READ_LAT(1), .BYPASS(1'b1), .CLEAR_ON_RST(1'b1)) u_a (
    .clk0(clk0), .rst0(rst0), .csb0(csb0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .csb1(csb1), .addr1(addr1), .dout1(dout_a), .dout1_vld(vld_a), .ready(rdy_a));

  sram_1r1w_param_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .READ_LAT(2), .BYPASS(1'b0), .CLEAR_ON_RST(1'b1)) u_b (
    .clk0(clk0), .rst0(rst0), .csb0(csb0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .csb1(csb1), .addr1(addr1), .dout1(dout_b), .dout1_vld(vld_b), .ready(rdy_b));

  // Reference model state
  logic [31:0] ref_mem [DEPTH];
  int          clear_left = DEPTH;
  logic        exp_ready = 1'b0;
  exp_t        q [2][$];

  int   cyc = 0;
  int   checks_total = 0;
  int   checks_passed = 0;
  logic armed = 1'b0;
  logic rst_at_edge = 1'b0;

  logic        vld_s [2];
  logic [31:0] dout_s [2];
  logic [31:0] last_dout [2];

  assign vld_s[0]  = vld_a;
  assign vld_s[1]  = vld_b;
  assign dout_s[0] = dout_a;
  assign dout_s[1] = dout_b;

  always @(posedge clk0) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst0;
    if (rst0) armed <= 1'b1;
  end

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] m);
    logic [31:0] w;
    w = old_w;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) w[8*i +: 8] = new_w[8*i +: 8];
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock of stimulus; the model applies the spec rules for the upcoming edge.
  task automatic step(input logic r, input logic c0, input logic [3:0] wm, input logic [5:0] a0,
                      input logic [31:0] d0, input logic c1, input logic [5:0] a1);
    logic [31:0] old;
    @(posedge clk0);
    #2;
    rst0 = r; csb0 = c0; wmask0 = wm; addr0 = a0; din0 = d0; csb1 = c1; addr1 = a1;
    exp_ready = (clear_left == 0);
    if (r) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
      clear_left = DEPTH;
    end else if (clear_left > 0) begin
      clear_left--;
    end else begin
      old = ref_mem[a1];
      if (!c1) begin
        q[0].push_back('{data: (!c0 && a0 == a1) ? merge(old, d0, wm) : old, due: cyc + 1});
        q[1].push_back('{data: old, due: cyc + 2});
      end
      if (!c0) ref_mem[a0] = merge(ref_mem[a0], d0, wm);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b1, 4'h0, 6'd0, 32'h0, 1'b1, 6'd0);
  endtask

  task automatic rand_step();
    step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 6'($urandom_range(0, 15)),
         $urandom, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)));
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b1, 4'h0, 6'd0, 32'h0, 1'b0, 6'(a));
  endtask

  // Monitor: ready level, read strobe timing, read data and hold behaviour.
  always @(negedge clk0) begin
    exp_t e;
    if (armed) begin
      if (rst_at_edge) begin
        last_dout[0] = 32'h0;
        last_dout[1] = 32'h0;
      end
      check("ready_lat1", {31'b0, rdy_a}, {31'b0, exp_ready});
      check("ready_lat2", {31'b0, rdy_b}, {31'b0, exp_ready});
      for (int ch = 0; ch < 2; ch++) begin
        if (vld_s[ch]) begin
          if (q[ch].size() == 0 || q[ch][0].due != cyc) begin
            check($sformatf("unexpected_vld_%0d", ch), {31'b0, vld_s[ch]}, 32'd0);
          end else begin
            e = q[ch].pop_front();
            check($sformatf("rd_data_%0d", ch), dout_s[ch], e.data);
            last_dout[ch] = e.data;
          end
        end else begin
          if (q[ch].size() > 0 && q[ch][0].due == cyc) begin
            void'(q[ch].pop_front());
            check($sformatf("missing_vld_%0d", ch), {31'b0, vld_s[ch]}, 32'd1);
          end
          check($sformatf("hold_%0d", ch), dout_s[ch], last_dout[ch]);
        end
      end
    end
  end

  initial begin
    last_dout[0] = 32'h0;
    last_dout[1] = 32'h0;
    rst0 = 1'b1; csb0 = 1'b1; csb1 = 1'b1;
    wmask0 = 4'h0; addr0 = 6'd0; addr1 = 6'd0; din0 = 32'h0;

    // Two-cycle reset, activity ignored during the sweep, then everything reads 0
    step(1'b1, 1'b1, 4'h0, 6'd0, 32'h0, 1'b1, 6'd0);
    step(1'b1, 1'b1, 4'h0, 6'd0, 32'h0, 1'b1, 6'd0);
    repeat (DEPTH) rand_step();
    read_all();

    // Dirty the array, reset, restart the sweep mid-way, then confirm it is zero
    for (int a = 0; a < DEPTH; a++) step(1'b0, 1'b0, 4'hF, 6'(a), $urandom | 32'h1, 1'b1, 6'd0);
    idle(3);
    step(1'b1, 1'b1, 4'h0, 6'd0, 32'h0, 1'b1, 6'd0);
    step(1'b1, 1'b1, 4'h0, 6'd0, 32'h0, 1'b1, 6'd0);
    repeat (20) rand_step();
    step(1'b1, 1'b0, 4'hF, 6'd3, 32'hDEADBEEF, 1'b0, 6'd3);
    repeat (DEPTH) step(1'b0, 1'b0, 4'hF, 6'($urandom_range(0, 63)), $urandom, 1'b0, 6'($urandom_range(0, 63)));
    read_all();

    // Byte-mask merge at address 5
    step(1'b0, 1'b0, 4'hF, 6'd5, 32'hAABBCCDD, 1'b1, 6'd0);
    step(1'b0, 1'b0, 4'b0101, 6'd5, 32'h11223344, 1'b1, 6'd0);
    step(1'b0, 1'b1, 4'h0, 6'd0, 32'h0, 1'b0, 6'd5);

    // Back-to-back reads
    step(1'b0, 1'b1, 4'h0, 6'd0, 32'h0, 1'b0, 6'd1);
    step(1'b0, 1'b1, 4'h0, 6'd0, 32'h0, 1'b0, 6'd2);
    step(1'b0, 1'b1, 4'h0, 6'd0, 32'h0, 1'b0, 6'd3);

    // Same-address collision at 9, then a plain read of 9
    step(1'b0, 1'b0, 4'b1100, 6'd9, 32'hFFFF0000, 1'b0, 6'd9);
    step(1'b0, 1'b1, 4'h0, 6'd0, 32'h0, 1'b0, 6'd9);

    // Output hold with the read port deselected
    step(1'b0, 1'b0, 4'hF, 6'd20, 32'h12345678, 1'b1, 6'd0);
    step(1'b0, 1'b1, 4'h0, 6'd0, 32'h0, 1'b0, 6'd20);
    repeat (10) step(1'b0, 1'($urandom_range(0, 1)), 4'hF, 6'($urandom_range(21, 63)), $urandom, 1'b1, 6'd0);

    repeat (600) rand_step();
    idle(4);
    check("drain_lat1", 32'(q[0].size()), 32'd0);
    check("drain_lat2", 32'(q[1].size()), 32'd0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
